// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands forward to the last round key,
// then emits round keys ROUNDS..0 over a valid/ready handshake.

module aes_inv_key_sched_sbox (
  input  logic       i_fDec,
  input  logic [7:0] i_Data,
  output logic [7:0] o_Data
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]}
         ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    o_Data = 8'h00;
    if (i_fDec) o_Data = gf_inv(inv_affine(i_Data));
    else        o_Data = affine(gf_inv(i_Data));
  end

endmodule

module aes_inv_key_sched #(
  parameter int ROUNDS = 10
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic         i_Abort,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_Round,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic         o_Busy,
  output logic         o_Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_EMIT
  } state_t;

  localparam logic [3:0] LP_ROUNDS = 4'(ROUNDS);
  localparam logic [3:0] LP_LAST   = 4'(ROUNDS + 1);

  state_t       r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic [3:0]   r_round;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_rcw;
  logic [7:0]   w_xt;
  logic [7:0]   w_ixt;
  logic         w_acc;

  assign w_k0 = r_key[127:96];
  assign w_k1 = r_key[95:64];
  assign w_k2 = r_key[63:32];
  assign w_k3 = r_key[31:0];

  assign w_p3 = w_k3 ^ w_k2;
  assign w_p2 = w_k2 ^ w_k1;
  assign w_p1 = w_k1 ^ w_k0;

  // The SBoxes are shared: forward rounds use w3, the backward step uses p3
  assign w_rot = (r_state == S_EMIT) ? {w_p3[23:0], w_p3[31:24]}
                                     : {w_k3[23:0], w_k3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_key_sched_sbox u_sbox (
      .i_fDec (1'b0),
      .i_Data (w_rot[8*g +: 8]),
      .o_Data (w_sub[8*g +: 8])
    );
  end

  assign w_rcw = {r_rcon, 24'h000000};

  assign w_f0 = w_k0 ^ w_sub ^ w_rcw;
  assign w_f1 = w_k1 ^ w_f0;
  assign w_f2 = w_k2 ^ w_f1;
  assign w_f3 = w_k3 ^ w_f2;

  assign w_p0 = w_k0 ^ w_sub ^ w_rcw;

  assign w_xt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_ixt = r_rcon[0] ? (((r_rcon ^ 8'h1b) >> 1) | 8'h80)
                           : (r_rcon >> 1);

  assign w_acc = r_valid & i_Ready;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_rcon  <= '0;
      r_cnt   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_Abort) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_round <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_Start) begin
              r_key   <= i_Key;
              r_rcon  <= 8'h01;
              r_cnt   <= 4'd1;
              r_state <= S_FWD;
              r_busy  <= 1'b1;
            end
          end
          S_FWD: begin
            if (r_cnt != LP_LAST) begin
              r_key <= {w_f0, w_f1, w_f2, w_f3};
              r_cnt <= r_cnt + 4'd1;
              // Rcon stays at Rcon[ROUNDS] for the first backward step
              if (r_cnt != LP_ROUNDS) r_rcon <= w_xt;
            end else begin
              r_state <= S_EMIT;
              r_round <= LP_ROUNDS;
              r_valid <= 1'b1;
            end
          end
          S_EMIT: begin
            if (w_acc) begin
              if (r_round != 4'd0) begin
                r_key   <= {w_p0, w_p1, w_p2, w_p3};
                r_round <= r_round - 4'd1;
                r_rcon  <= w_ixt;
              end else begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_RoundKey = r_valid ? r_key : '0;
  assign o_Round    = r_round;
  assign o_Valid    = r_valid;
  assign o_Busy     = r_busy;
  assign o_Done     = r_done;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized bench for aes_inv_key_sched against a word-level
// FIPS-197 key expansion model.

module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic         i_Start;
  logic [127:0] i_Key;
  logic         i_Abort;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Valid;
  logic         i_Ready;
  logic         o_Busy;
  logic         o_Done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] ref_rk [0:10];

  logic [127:0] acc_key [0:15];
  int           acc_round [0:15];
  int           n_acc;
  int           lat;
  int           done_cyc;
  int           stall_bad;
  bit           timeout;
  bit           busy1;

  aes_inv_key_sched #(.ROUNDS(10)) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Start    (i_Start),
    .i_Key      (i_Key),
    .i_Abort    (i_Abort),
    .o_RoundKey (o_RoundKey),
    .o_Round    (o_Round),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rotl8(input int v, input int s);
    return ((v << s) | (v >> (8 - s))) & 'hff;
  endfunction

  // SBox table built by walking the generator 3 and its inverse
  task automatic init_sbox;
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
      q = (q ^ (q << 1)) & 'hff;
      q = (q ^ (q << 2)) & 'hff;
      q = (q ^ (q << 4)) & 'hff;
      if ((q & 'h80) != 0) q = q ^ 'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = 8'(x ^ 'h63);
    end while (p != 1);
    sb[0] = 8'h63;
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {8'(rc), 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Starts a run and records every accepted key; no judging here
  task automatic collect(input logic [127:0] key, input bit rnd_ready,
                         input bit inj_start, input bit start_at_last);
    logic [127:0] pk;
    logic [3:0]   pr;
    bit           pv, pready;
    n_acc = 0; lat = -1; done_cyc = -1; stall_bad = 0;
    timeout = 1; busy1 = 0;
    pk = '0; pr = '0; pv = 0; pready = 0;
    i_Key = key; i_Start = 1; i_Ready = 0;
    @(posedge clk); #1;
    i_Start = 0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      i_Start = 0;
      if (cyc == 1) busy1 = o_Busy;
      if (o_Done) begin
        done_cyc = cyc;
        timeout = 0;
        break;
      end
      if (o_Valid && lat < 0) lat = cyc;
      if (pv && !pready && (!o_Valid || o_RoundKey !== pk || o_Round !== pr))
        stall_bad++;
      i_Ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_Valid && i_Ready) begin
        if (n_acc < 16) begin
          acc_key[n_acc] = o_RoundKey;
          acc_round[n_acc] = int'(o_Round);
        end
        n_acc++;
        if (start_at_last && o_Round == 4'd0) begin
          i_Start = 1; i_Key = ~key;
        end
      end
      if (inj_start && (cyc == 3 || cyc == 14)) begin
        i_Start = 1; i_Key = ~key;
      end
      pv = o_Valid; pready = i_Ready; pk = o_RoundKey; pr = o_Round;
    end
    i_Ready = 0; i_Start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; i_Start = 0; i_Abort = 0; i_Ready = 0; i_Key = '0;
    #2;
    checks++;
    if (o_RoundKey !== '0 || o_Round !== 4'd0 || o_Valid !== 1'b0 ||
        o_Busy !== 1'b0 || o_Done !== 1'b0)
      begin errors++; $display("FAIL reset: key=%h rnd=%0d v=%b b=%b d=%b exp all 0",
        o_RoundKey, o_Round, o_Valid, o_Busy, o_Done); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (o_Valid !== 1'b0 || o_Busy !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: v=%b b=%b exp 0 0",
        o_Valid, o_Busy); end
  endtask

  task automatic test_fips;
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(k);
    collect(k, 0, 0, 0);
    checks++;
    if (timeout) begin errors++; $display("FAIL fips_timeout: no o_Done"); end
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL fips_busy: got %b exp 1", busy1); end
    checks++;
    if (lat != 11) begin errors++; $display("FAIL fips_latency: got %0d exp 11", lat); end
    checks++;
    if (n_acc != 11) begin errors++; $display("FAIL fips_accepts: got %0d exp 11", n_acc); end
    checks++;
    if (acc_round[0] != 10 || acc_key[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      begin errors++; $display("FAIL fips_r10: got %0d %h exp 10 d014f9a8c9ee2589e13f0cc8b6630ca6",
        acc_round[0], acc_key[0]); end
    checks++;
    if (acc_round[1] != 9 || acc_key[1] !== 128'hac7766f319fadc2128d12941575c006e)
      begin errors++; $display("FAIL fips_r9: got %0d %h exp 9 ac7766f319fadc2128d12941575c006e",
        acc_round[1], acc_key[1]); end
    checks++;
    if (acc_round[10] != 0 || acc_key[10] !== k)
      begin errors++; $display("FAIL fips_r0: got %0d %h exp 0 %h", acc_round[10], acc_key[10], k); end
    checks++;
    if (done_cyc != 22) begin errors++; $display("FAIL fips_done_time: got %0d exp 22", done_cyc); end
    checks++;
    if (o_Busy !== 1'b0 || o_Valid !== 1'b0)
      begin errors++; $display("FAIL fips_done_state: b=%b v=%b exp 0 0", o_Busy, o_Valid); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
        begin errors++; $display("FAIL fips_seq[%0d]: got %0d %h exp %0d %h",
          i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (o_Done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse: got %b exp 0", o_Done); end
  endtask

  task automatic test_stall;
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(k);
    collect(k, 1, 0, 0);
    checks++;
    if (timeout) begin errors++; $display("FAIL stall_timeout: no o_Done"); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_stable: got %0d changes exp 0", stall_bad); end
    checks++;
    if (n_acc != 11) begin errors++; $display("FAIL stall_accepts: got %0d exp 11", n_acc); end
    for (int i = 0; i < 11 && i < n_acc; i++) begin
      checks++;
      if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
        begin errors++; $display("FAIL stall_seq[%0d]: got %0d %h exp %0d %h",
          i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
    end
  endtask

  task automatic test_zero_key;
    model('0);
    collect('0, 0, 0, 0);
    checks++;
    if (n_acc != 11 || timeout)
      begin errors++; $display("FAIL zero_accepts: got %0d timeout=%b exp 11 0", n_acc, timeout); end
    checks++;
    if (acc_key[0] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
      begin errors++; $display("FAIL zero_r10: got %h exp b4ef5bcb3e92e21123e951cf6f8f188e", acc_key[0]); end
    checks++;
    if (acc_round[9] != 1 || acc_key[9] !== 128'h62636363626363636263636362636363)
      begin errors++; $display("FAIL zero_r1: got %0d %h exp 1 62636363626363636263636362636363",
        acc_round[9], acc_key[9]); end
  endtask

  task automatic test_random_keys;
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model(k);
      collect(k, n[0], 0, 0);
      checks++;
      if (n_acc != 11 || timeout)
        begin errors++; $display("FAIL rand%0d_accepts: got %0d timeout=%b exp 11 0", n, n_acc, timeout); end
      for (int i = 0; i < 11 && i < n_acc; i++) begin
        checks++;
        if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
          begin errors++; $display("FAIL rand%0d_seq[%0d]: got %0d %h exp %0d %h",
            n, i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    collect(k, 1, 1, 1);
    checks++;
    if (n_acc != 11 || timeout)
      begin errors++; $display("FAIL ign_accepts: got %0d timeout=%b exp 11 0", n_acc, timeout); end
    for (int i = 0; i < 11 && i < n_acc; i++) begin
      checks++;
      if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
        begin errors++; $display("FAIL ign_seq[%0d]: got %0d %h exp %0d %h",
          i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL ign_last_start: busy=%b exp 0", o_Busy); end
  endtask

  task automatic test_abort;
    logic [127:0] k;
    bit found;
    int dones;
    k = {$urandom, $urandom, $urandom, $urandom};
    i_Key = k; i_Start = 1; i_Abort = 1;
    @(posedge clk); #1;
    i_Start = 0; i_Abort = 0;
    checks++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL abort_prio: busy=%b exp 0", o_Busy); end
    i_Start = 1; i_Ready = 1;
    @(posedge clk); #1;
    i_Start = 0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (o_Valid && o_Round == 4'd5) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach5: round 5 not seen"); end
    i_Abort = 1;
    @(posedge clk); #1;
    i_Abort = 0; i_Ready = 0;
    checks++;
    if (o_Valid !== 1'b0 || o_Busy !== 1'b0 || o_Done !== 1'b0)
      begin errors++; $display("FAIL abort_idle: v=%b b=%b d=%b exp 0 0 0", o_Valid, o_Busy, o_Done); end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (o_Done || o_Valid) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles exp 0", dones); end
    model(k);
    collect(k, 0, 0, 0);
    checks++;
    if (n_acc != 11 || timeout)
      begin errors++; $display("FAIL abort_restart: got %0d timeout=%b exp 11 0", n_acc, timeout); end
    for (int i = 0; i < 11 && i < n_acc; i++) begin
      checks++;
      if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
        begin errors++; $display("FAIL abort_seq[%0d]: got %0d %h exp %0d %h",
          i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    i_Key = k; i_Start = 1;
    @(posedge clk); #1;
    i_Start = 0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    checks++;
    if (o_RoundKey !== '0 || o_Round !== 4'd0 || o_Valid !== 1'b0 ||
        o_Busy !== 1'b0 || o_Done !== 1'b0)
      begin errors++; $display("FAIL rst_mid: key=%h rnd=%0d v=%b b=%b d=%b exp all 0",
        o_RoundKey, o_Round, o_Valid, o_Busy, o_Done); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    model(k);
    collect(k, 1, 0, 0);
    checks++;
    if (n_acc != 11 || timeout)
      begin errors++; $display("FAIL rst_restart: got %0d timeout=%b exp 11 0", n_acc, timeout); end
    for (int i = 0; i < 11 && i < n_acc; i++) begin
      checks++;
      if (acc_round[i] != 10 - i || acc_key[i] !== ref_rk[10-i])
        begin errors++; $display("FAIL rst_seq[%0d]: got %0d %h exp %0d %h",
          i, acc_round[i], acc_key[i], 10 - i, ref_rk[10-i]); end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_zero_key();
    test_random_keys();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
